// File: rtl/select_operand_pipe.sv
// select_operand_pipe: accepts operand sets, pre-decodes the priority select
//    into a registered one-hot vector and presents everything from flops.
// Latency: 1 cycle from input acceptance to o_valid; throughput 1 set/cycle.
// Backpressure: 2-entry skid (main + skid); o_ready = !skid_valid from a flop,
//    o_valid never depends combinationally on i_ready.
// Ports:
//    i_clk, i_rst          clock, asynchronous active-high reset
//    i_valid/o_ready       upstream handshake carrying i_a, i_b, i_c, i_cond1, i_cond2
//    o_valid/i_ready       downstream handshake carrying o_a, o_b, o_c, o_sel
//    o_sel                 one-hot: bit2 = B path, bit1 = A path, bit0 = C path
//    o_cntB/o_cntA/o_cntC  saturating per-path transfer counts
// Optional feature macro: SELPIPE_STATS_EN (enables the o_cnt* ports and counters).
module select_operand_pipe #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned THRESH = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_c,
   input  logic             i_cond1,
   input  logic             i_cond2,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b,
   output logic [WIDTH-1:0] o_c,
   output logic [2:0]       o_sel
`ifdef SELPIPE_STATS_EN
   ,
   output logic [CNT_W-1:0] o_cntB,
   output logic [CNT_W-1:0] o_cntA,
   output logic [CNT_W-1:0] o_cntC
`endif
);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] c;
      logic [2:0]       sel;
   } entry_t;

   // One extra bit so THRESH = 2**WIDTH is still representable.
   localparam logic [WIDTH:0] THRESH_EXT = (WIDTH+1)'(THRESH);

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   ready_q, ready_d;

   logic   in_xfer;
   logic   out_xfer;
   logic   sel_b, sel_a, sel_c;
   entry_t in_ent;

   assign in_xfer  = i_valid && ready_q;
   assign out_xfer = main_valid_q && i_ready;

   // Priority decode happens on the way in so the stored select is a flop.
   always_comb begin
      sel_b      = i_cond2 && !i_cond1 && ({1'b0, i_c} < THRESH_EXT);
      sel_a      = !sel_b && i_cond1;
      sel_c      = !sel_b && !sel_a;
      in_ent.a   = i_a;
      in_ent.b   = i_b;
      in_ent.c   = i_c;
      in_ent.sel = {sel_b, sel_a, sel_c};
   end

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (!main_valid_q) begin
         // Skid is always empty when main is empty.
         if (in_xfer) begin
            main_d       = in_ent;
            main_valid_d = 1'b1;
         end
      end else if (out_xfer) begin
         if (skid_valid_q) begin
            // o_ready was low, so no input can arrive this cycle.
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (in_xfer) begin
            main_d = in_ent;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_xfer) begin
         skid_d       = in_ent;
         skid_valid_d = 1'b1;
      end
      ready_d = !skid_valid_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
      end
   end

   assign o_valid = main_valid_q;
   assign o_ready = ready_q;
   assign o_a     = main_q.a;
   assign o_b     = main_q.b;
   assign o_c     = main_q.c;
   assign o_sel   = main_q.sel;

`ifdef SELPIPE_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_c_q, cnt_c_d;

   // Counters saturate rather than wrap.
   always_comb begin
      cnt_b_d = cnt_b_q;
      cnt_a_d = cnt_a_q;
      cnt_c_d = cnt_c_q;
      if (out_xfer) begin
         if (main_q.sel[2] && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CNT_W'(1);
         if (main_q.sel[1] && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CNT_W'(1);
         if (main_q.sel[0] && (cnt_c_q != CNT_MAX)) cnt_c_d = cnt_c_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_b_q <= '0;
         cnt_a_q <= '0;
         cnt_c_q <= '0;
      end else begin
         cnt_b_q <= cnt_b_d;
         cnt_a_q <= cnt_a_d;
         cnt_c_q <= cnt_c_d;
      end
   end

   assign o_cntB = cnt_b_q;
   assign o_cntA = cnt_a_q;
   assign o_cntC = cnt_c_q;
`else
   // Counter width only matters when the statistics are built in.
   logic unused_cnt_w;
   assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_select_operand_pipe.sv
// Bench for select_operand_pipe: random and directed operand sets checked
// against a queue-based reference of the pipe contents and the decode rules.
module tb_select_operand_pipe;

   localparam int WIDTH  = 8;
   localparam int THRESH = 8;
   localparam int CNT_W  = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_valid = 1'b0;
   logic             o_ready;
   logic [WIDTH-1:0] i_a = '0, i_b = '0, i_c = '0;
   logic             i_cond1 = 1'b0, i_cond2 = 1'b0;
   logic             o_valid;
   logic             i_ready = 1'b0;
   logic [WIDTH-1:0] o_a, o_b, o_c;
   logic [2:0]       o_sel;
`ifdef SELPIPE_STATS_EN
   logic [CNT_W-1:0] cnt_b, cnt_a, cnt_c;
`endif

   select_operand_pipe #(.WIDTH(WIDTH), .THRESH(THRESH), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_cond1(i_cond1), .i_cond2(i_cond2),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_a(o_a), .o_b(o_b), .o_c(o_c), .o_sel(o_sel)
`ifdef SELPIPE_STATS_EN
      , .o_cntB(cnt_b), .o_cntA(cnt_a), .o_cntC(cnt_c)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: the pipe is a FIFO of at most two sets; decode by priority.
   typedef struct {
      logic [WIDTH-1:0] a, b, c;
      logic [2:0]       sel;
   } exp_t;

   exp_t q[$];
   int   out_cnt = 0;
   int   tot_b = 0, tot_a = 0, tot_c = 0;
   bit   done = 0;

   function automatic logic [2:0] ref_sel(input logic c1, input logic c2, input logic [WIDTH-1:0] c);
      if (c2 && !c1 && (int'(c) < THRESH)) return 3'b100;
      else if (c1)                          return 3'b010;
      else                                  return 3'b001;
   endfunction

   function automatic int sat(input int v);
      int mx = (1 << CNT_W) - 1;
      return (v > mx) ? mx : v;
   endfunction

   // Inputs change just after posedge; outputs and handshakes are sampled here.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         tot_b = 0; tot_a = 0; tot_c = 0;
         chk("rst_o_valid", o_valid, 0);
         chk("rst_o_ready", o_ready, 1);
      end else begin
         chk("o_valid", o_valid, q.size() > 0);
         chk("o_ready", o_ready, q.size() < 2);
         if (q.size() > 0) begin
            chk("o_a", o_a, q[0].a);
            chk("o_b", o_b, q[0].b);
            chk("o_c", o_c, q[0].c);
            chk("o_sel", o_sel, q[0].sel);
         end
`ifdef SELPIPE_STATS_EN
         chk("cnt_b", cnt_b, sat(tot_b));
         chk("cnt_a", cnt_a, sat(tot_a));
         chk("cnt_c", cnt_c, sat(tot_c));
`endif
         if (o_valid && i_ready && q.size() > 0) begin
            if (q[0].sel == 3'b100) tot_b++;
            if (q[0].sel == 3'b010) tot_a++;
            if (q[0].sel == 3'b001) tot_c++;
            void'(q.pop_front());
            out_cnt++;
         end
         if (i_valid && o_ready) begin
            exp_t e;
            e.a = i_a; e.b = i_b; e.c = i_c;
            e.sel = ref_sel(i_cond1, i_cond2, i_c);
            q.push_back(e);
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic c1, input logic c2);
      bit acc = 0;
      int n   = 0;
      i_valid = 1'b1; i_a = a; i_b = b; i_c = c; i_cond1 = c1; i_cond2 = c2;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk);
         #1;
         n++;
      end
      chk("send_accepted", acc, 1);
      i_valid = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      // Reset then idle
      step(2);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_valid", o_valid, 0);
         chk("idle_ready", o_ready, 1);
         chk("idle_sel", o_sel, 0);
         chk("idle_data", {o_a, o_b, o_c}, 0);
      end
      step(1);

      // Priority decode, including the c == THRESH boundary
      i_ready = 1'b1;
      send(8'h11, 8'h22, 8'h05, 1'b0, 1'b1);
      send(8'h11, 8'h22, 8'h08, 1'b0, 1'b1);
      send(8'h11, 8'h22, 8'h07, 1'b0, 1'b1);
      send(8'h11, 8'h22, 8'h00, 1'b1, 1'b1);
      send(8'h11, 8'h22, 8'h00, 1'b0, 1'b0);
      send(8'h33, 8'h44, 8'hFF, 1'b1, 1'b0);
      step(3);

      // Backpressure: two sets fill main+skid, third waits upstream
      i_ready = 1'b0;
      fork
         begin
            send(8'd1, 8'h0, 8'h0, 1'b0, 1'b0);
            send(8'd2, 8'h0, 8'h0, 1'b0, 1'b0);
            send(8'd3, 8'h0, 8'h0, 1'b0, 1'b0);
         end
         begin
            step(6);
            @(negedge clk);
            chk("bp_stall_a", o_a, 8'd1);
            chk("bp_stall_ready", o_ready, 0);
            base = out_cnt;
            @(posedge clk); #1;
            i_ready = 1'b1;
            step(3);
            chk("bp_no_gaps", out_cnt - base, 3);
         end
      join
      step(3);

      // Streaming: 256 random sets, one per cycle
      base = out_cnt;
      for (int i = 0; i < 256; i++)
         send(WIDTH'($urandom), WIDTH'($urandom),
              ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom),
              1'($urandom), 1'($urandom));
      step(1);
      @(negedge clk);
      chk("stream_count", out_cnt - base, 256);
      step(2);

      // Random backpressure
      done = 0;
      fork
         begin
            for (int i = 0; i < 100; i++)
               send(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom));
            done = 1;
         end
         begin
            while (!done) begin
               i_ready = 1'($urandom);
               step(1);
            end
         end
      join
      i_ready = 1'b1;
      step(4);
      @(negedge clk);
      chk("drained", q.size(), 0);

      // Reset mid-stall with main and skid full
      step(1);
      i_ready = 1'b0;
      send(8'hA1, 8'h01, 8'h01, 1'b0, 1'b1);
      send(8'hA2, 8'h02, 8'h02, 1'b1, 1'b0);
      @(negedge clk);
      chk("pre_rst_ready", o_ready, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", o_valid, 0);
      chk("async_rst_ready", o_ready, 1);
      step(2);
      rst = 1'b0;
      i_ready = 1'b1;
      base = out_cnt;
      step(10);
      chk("no_stale_out", out_cnt - base, 0);

`ifdef SELPIPE_STATS_EN
      // Saturation: 20 B-path, 3 A-path, no C-path after a fresh reset
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) send(WIDTH'(i), 8'h0, 8'h01, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)  send(WIDTH'(i), 8'h0, 8'h01, 1'b1, 1'b0);
      step(3);
      @(negedge clk);
      chk("stat_cnt_b", cnt_b, 15);
      chk("stat_cnt_a", cnt_a, 3);
      chk("stat_cnt_c", cnt_c, 0);
`endif

      step(1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/select_operand_pipe.md
Name: select_operand_pipe

Overview:
- Upstream feeder for the registered priority-select stage.
- Accepts operand sets (a, b, c, cond1, cond2) over a valid/ready handshake and pre-decodes the priority select into a registered one-hot vector, so the downstream mux sees only flop outputs.
- A 2-entry skid buffer gives full throughput with a registered o_ready.

Parameters:
- WIDTH, 8, operand width in bits
- THRESH, 8, c-threshold for the B path; selB requires c < THRESH, unsigned compare
- CNT_W, 16, width of the optional statistics counters

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous reset, active-high
- i_valid  input  1  upstream operand set valid
- o_ready  output  1  block can accept; registered
- i_a  input  WIDTH  operand A
- i_b  input  WIDTH  operand B
- i_c  input  WIDTH  operand C
- i_cond1  input  1  condition 1
- i_cond2  input  1  condition 2
- o_valid  output  1  output operand set valid
- i_ready  input  1  downstream accepts
- o_a  output  WIDTH  registered A
- o_b  output  WIDTH  registered B
- o_c  output  WIDTH  registered C
- o_sel  output  3  one-hot select: bit2=B, bit1=A, bit0=C
- o_cntB, o_cntA, o_cntC  output  CNT_W each  per-path transfer counts; only present with SELPIPE_STATS_EN

Behaviour:
- Reset (async assert, synchronous-to-clock deassert handled by the top level) forces:
  - main_valid=0, skid_valid=0, so o_valid=0 and o_ready=1
  - all data registers and o_sel to 0
- Reset mid-operation discards all held entries. No partial transfer completes.
- Handshake:
  - Input transfer when i_valid && o_ready.
  - Output transfer when o_valid && i_ready.
  - o_valid does not depend combinationally on i_ready.
  - o_ready = !skid_valid, driven from a flop.
- Pre-decode, computed on the input side and stored with the data:
  - selB = i_cond2 && !i_cond1 && (i_c < THRESH)
  - selA = !selB && i_cond1
  - selC = !selB && !selA
  - o_sel is always exactly one-hot whenever o_valid=1.
- Storage: a main register (drives outputs) and a skid register. Per clock:
  - Main empty, input transfer: load main. o_valid=1 next cycle, so latency is 1 cycle.
  - Main full, output transfer, input transfer, skid empty: main reloads from input. Throughput is 1 per cycle.
  - Main full, no output transfer, input transfer: load skid. o_ready=0 next cycle.
  - Main full, output transfer, skid full: main loads from skid and skid empties. o_ready=1 next cycle. No input transfer is possible that cycle because o_ready=0.
  - Main full, output transfer, no input, skid empty: main_valid=0 next cycle.
- Stall rule: while o_valid && !i_ready, o_a/o_b/o_c/o_sel hold stable.
- Ordering: strict FIFO order, no reordering, no drops, no duplicates.
- Data registers update only when loaded; contents when the corresponding valid=0 are don't-care but deterministic.
- No bypass path from input to output. Every output is a flop.

Optional Feature:
- Macro: SELPIPE_STATS_EN
- Defined:
  - o_cntB/o_cntA/o_cntC exist; each resets to 0.
  - Each increments by 1 on an output transfer whose o_sel has the matching bit set.
  - Each saturates at 2^CNT_W-1 and does not wrap.
- Undefined:
  - The counter ports and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: i_rst pulse, i_valid=0 -> o_valid=0, o_ready=1, o_sel=000, all data 0 for 10 cycles.
- Priority decode, i_ready=1, one set per cycle, each appearing 1 cycle after acceptance:
  - a=0x11, b=0x22, c=0x05, cond1=0, cond2=1 -> o_sel=100
  - c=0x08, same conds -> o_sel=001 (boundary, not < 8)
  - cond1=1, cond2=1, c=0x00 -> o_sel=010
  - cond1=0, cond2=0 -> o_sel=001
- Backpressure: i_ready=0, push sets 1,2,3 (a=1,2,3) back-to-back:
  - sets 1 and 2 accepted; o_ready=0 after set 2; set 3 held by upstream
  - o_a=1 stable throughout
  - raise i_ready -> outputs a=1,2,3 in order, no gaps after release
- Streaming: 256 random sets, i_valid=1, i_ready=1 -> 256 output transfers in consecutive cycles, each matching the reference model of the decode.
- Reset mid-stall: skid and main both full, assert i_rst -> o_valid=0 and o_ready=1 immediately (async); after release no stale sets emerge.
- SELPIPE_STATS_EN, CNT_W=4: 20 B-path transfers, 3 A-path, 0 C-path -> o_cntB=15 (saturated), o_cntA=3, o_cntC=0.
